// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: latches hex digits on load, swaps
// them in at frame boundaries only, and scans one digit at a time onto seg/anode lines.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] in_nums,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic [NUM_DIGITS-1:0]   in_blank,
  output logic [7:0]              seg_code,
  output logic [NUM_DIGITS-1:0]   an_sel,
  output logic                    frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0]            SEG_DARK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_NONE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] shadow_nums, active_nums;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;
  logic                    pending;

  logic                    div_last;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    upper_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign div_last  = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign frame_end = div_last && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // A digit is leading-blanked when it and every more significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero  = upper_zero && (active_nums[4*k +: 4] == 4'h0);
      lz_blank[k] = (BLANK_LEADING != 0) && (k > 0) && upper_zero;
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_next  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib    = active_nums[4*k +: 4];
        cur_dp     = active_dp[k];
        cur_dark   = active_blank[k] || lz_blank[k];
        an_next[k] = 1'b1;
      end
    end
    seg_next = {cur_dp, cur_dark ? 7'h00 : glyph(cur_nib)};
    if (SEG_ACTIVE_LOW != 0) seg_next = ~seg_next;
    if (AN_ACTIVE_LOW != 0)  an_next  = ~an_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_last) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // Active data only changes on a frame boundary so a frame never mixes two loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_nums  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      active_nums  <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      pending      <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        active_nums  <= in_nums;
        active_dp    <= in_dp;
        active_blank <= in_blank;
      end else if (pending) begin
        active_nums  <= shadow_nums;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow_nums  <= in_nums;
      shadow_dp    <= in_dp;
      shadow_blank <= in_blank;
      pending      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_code   <= SEG_DARK;
      an_sel     <= AN_NONE;
      frame_tick <= 1'b0;
    end else begin
      seg_code   <= seg_next;
      an_sel     <= an_next;
      frame_tick <= frame_end;
    end
  end

endmodule
